// File: rtl/mc_ifu.sv
// mc_ifu: instruction fetch unit for a multi-cycle MIPS-style core.
// Holds the PC register, the instruction register and a read-only
// instruction memory (im) that a bench loads with direct writes.
// The PC is advanced by the controller through pc_wr/npc_sel; the IR is
// loaded from the word addressed by the current PC when ir_wr is high.
// Optional feature: define IFU_ADDR_CHECK_EN to enable fetch address checking
// (misaligned or out-of-image fetches load a nop and set sticky fetch_err).
// Without the macro fetch_err is tied low and the memory index simply wraps.
module mc_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_wr,
    input  logic        ir_wr,
    input  logic [1:0]  npc_sel,
    input  logic        br_cond,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_err
);

    // Word index width; with the default depth this selects pc[11:2].
    localparam int IDX_W = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_REG    = 2'b11
    } npc_sel_e;

    // Instruction memory: contents are owned by whoever loads the image.
    logic [31:0] im [0:IM_WORDS-1];

    logic [IDX_W-1:0] imIdx;
    logic [31:0]      fetchWord;
    logic [31:0]      fetchData;
    logic [31:0]      brOffset;
    logic [31:0]      npc;
    npc_sel_e         npcSel;

    assign npcSel    = npc_sel_e'(npc_sel);
    assign imIdx     = pc[IDX_W+1:2];
    assign fetchWord = im[imIdx];
    assign brOffset  = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Next-PC selection; a not-taken branch keeps the PC that was already
    // advanced during the fetch cycle.
    always_comb begin
        npc = pc + 32'd4;
        case (npcSel)
            NPC_SEQ:    npc = pc + 32'd4;
            NPC_BRANCH: npc = br_cond ? (pc + brOffset) : pc;
            NPC_JUMP:   npc = {pc[31:28], instr[25:0], 2'b00};
            NPC_REG:    npc = jr_addr;
            default:    npc = pc + 32'd4;
        endcase
    end

`ifdef IFU_ADDR_CHECK_EN
    localparam logic [31:0] IM_LAST = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;

    logic addrBad;

    // A fetch is bad when misaligned or outside the loaded image window.
    always_comb begin
        addrBad   = (pc[1:0] != 2'b00) || (pc < RESET_PC) || (pc > IM_LAST);
        fetchData = addrBad ? 32'h0000_0000 : fetchWord;
    end

    // Sticky fault flag: set by any bad fetch, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (ir_wr && addrBad) begin
            fetch_err <= 1'b1;
        end
    end
`else
    assign fetchData = fetchWord;
    assign fetch_err = 1'b0;
`endif

    // PC / IR / valid registers; reset wins over both write enables, and a
    // combined pc_wr+ir_wr edge fetches from the old PC while advancing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= 32'h0000_0000;
            instr_valid <= 1'b0;
        end else begin
            if (pc_wr) begin
                pc <= npc;
            end
            if (ir_wr) begin
                instr       <= fetchData;
                instr_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_ifu.sv
// tb_mc_ifu: self-checking bench for mc_ifu.
// A behavioural model of the fetch unit runs alongside the DUT; a compare
// process checks every output on each falling edge, and directed sequences
// pin the model with hand-computed literal values.
module tb_mc_ifu;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          IM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_wr = 1'b0;
    logic        ir_wr = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic        br_cond = 1'b0;
    logic [31:0] jr_addr = 32'h0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_err;

    int testsRun = 0;
    int testsFailed = 0;

    // Model state
    logic [31:0] memModel [0:IM_WORDS-1];
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic        mValid;
    logic        mErr;
    bit          compareEn = 1'b0;

    mc_ifu #(
        .RESET_PC (RESET_PC),
        .IM_WORDS (IM_WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_wr       (pc_wr),
        .ir_wr       (ir_wr),
        .npc_sel     (npc_sel),
        .br_cond     (br_cond),
        .jr_addr     (jr_addr),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure line if it misses.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Write one memory word into both the DUT image and the model.
    task automatic loadWord(input int idx, input logic [31:0] data);
        dut.im[idx]   = data;
        memModel[idx] = data;
    endtask

    // Word the model fetches for a given byte address (index wraps with depth).
    function automatic logic [31:0] modelFetch(input logic [31:0] addr);
        int unsigned wordIdx;
        wordIdx = (addr / 4) % IM_WORDS;
        return memModel[wordIdx];
    endfunction

    function automatic bit modelBadAddr(input logic [31:0] addr);
        longint unsigned lo;
        longint unsigned hi;
        lo = longint'(RESET_PC);
        hi = lo + 4 * IM_WORDS - 4;
        return (addr % 4 != 0) || (longint'(addr) < lo) || (longint'(addr) > hi);
    endfunction

    // Next PC from the architectural rules: sequential, branch, jump, register.
    function automatic logic [31:0] modelNpc(input logic [1:0] sel, input logic bc,
                                             input logic [31:0] curPc, input logic [31:0] ir,
                                             input logic [31:0] jr);
        int          imm;
        logic [31:0] result;
        result = curPc + 32'd4;
        if (sel == 2'd0) begin
            result = curPc + 32'd4;
        end else if (sel == 2'd1) begin
            imm    = int'($signed(ir[15:0]));
            result = bc ? curPc + 32'(imm * 4) : curPc;
        end else if (sel == 2'd2) begin
            result = (curPc & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 4);
        end else begin
            result = jr;
        end
        return result;
    endfunction

    // Drive one cycle of inputs, step the model across the rising edge.
    task automatic applyStimulus(input logic r, input logic pw, input logic iw,
                                 input logic [1:0] sel, input logic bc, input logic [31:0] jr);
        logic [31:0] nPc;
        logic [31:0] nInstr;
        logic        nValid;
        logic        nErr;
        @(negedge clk);
        #1;
        rst     = r;
        pc_wr   = pw;
        ir_wr   = iw;
        npc_sel = sel;
        br_cond = bc;
        jr_addr = jr;
        nPc    = mPc;
        nInstr = mInstr;
        nValid = mValid;
        nErr   = mErr;
        if (r) begin
            nPc    = RESET_PC;
            nInstr = 32'h0;
            nValid = 1'b0;
            nErr   = 1'b0;
        end else begin
            if (pw) nPc = modelNpc(sel, bc, mPc, mInstr, jr);
            if (iw) begin
                nInstr = modelFetch(mPc);
                nValid = 1'b1;
`ifdef IFU_ADDR_CHECK_EN
                if (modelBadAddr(mPc)) begin
                    nInstr = 32'h0;
                    nErr   = 1'b1;
                end
`endif
            end
        end
        @(posedge clk);
        mPc    = nPc;
        mInstr = nInstr;
        mValid = nValid;
        mErr   = nErr;
        #1;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (compareEn) begin
            checkOutput("pc", pc, mPc);
            checkOutput("instr", instr, mInstr);
            checkOutput("instr_valid", 32'(instr_valid), 32'(mValid));
            checkOutput("fetch_err", 32'(fetch_err), 32'(mErr));
        end
    end

    initial begin
        mPc    = 32'hx;
        mInstr = 32'hx;
        mValid = 1'bx;
        mErr   = 1'bx;
        for (int i = 0; i < IM_WORDS; i++) begin
            loadWord(i, $urandom);
        end
        loadWord(0, 32'h2008_0005);
        loadWord(1, 32'h0411_FFFE);
        loadWord(2, 32'h0C00_0C10);

        // Reset held for two edges
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        compareEn = 1'b1;
        checkOutput("reset pc", pc, 32'h0000_3000);
        checkOutput("reset instr", instr, 32'h0);
        checkOutput("reset valid", 32'(instr_valid), 32'h0);

        // Fetch and increment in one cycle
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        checkOutput("fetch instr", instr, 32'h2008_0005);
        checkOutput("fetch pc", pc, 32'h0000_3004);
        checkOutput("fetch valid", 32'(instr_valid), 32'h1);

        // Load the branch into IR, then take it (imm = -2)
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        checkOutput("ir only instr", instr, 32'h0411_FFFE);
        checkOutput("ir only pc", pc, 32'h0000_3004);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0);
        checkOutput("branch taken pc", pc, 32'h0000_2FFC);

        // Return via register, then branch not taken
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_3004);
        checkOutput("jr back pc", pc, 32'h0000_3004);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0);
        checkOutput("branch not taken pc", pc, 32'h0000_3004);

        // Jump: fetch the j instruction from 0x3008 and execute it
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_3008);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        checkOutput("jump instr", instr, 32'h0C00_0C10);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
        checkOutput("jump pc", pc, 32'h0000_3040);

        // Register jump then a hold cycle
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_3010);
        checkOutput("jr pc", pc, 32'h0000_3010);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'hDEAD_BEEC);
        checkOutput("hold pc", pc, 32'h0000_3010);
        checkOutput("hold instr", instr, 32'h0C00_0C10);

        // Mid-program reset keeps memory; refetch word 0
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 32'h0000_3100);
        checkOutput("mid reset pc", pc, 32'h0000_3000);
        checkOutput("mid reset valid", 32'(instr_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        checkOutput("refetch instr", instr, 32'h2008_0005);

`ifdef IFU_ADDR_CHECK_EN
        // Misaligned fetch gives nop and a sticky error
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_3002);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        checkOutput("bad fetch instr", instr, 32'h0);
        checkOutput("bad fetch err", 32'(fetch_err), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_3000);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        checkOutput("good fetch instr", instr, 32'h2008_0005);
        checkOutput("sticky err", 32'(fetch_err), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        checkOutput("err cleared", 32'(fetch_err), 32'h0);
`endif

        // Randomized traffic: mostly in-image register targets, some wild ones
        for (int n = 0; n < 3000; n++) begin
            logic        r;
            logic [31:0] jr;
            r  = ($urandom_range(0, 99) < 2);
            jr = ($urandom_range(0, 9) < 8) ? (RESET_PC + 32'($urandom_range(0, IM_WORDS - 1) * 4))
                                              : 32'($urandom);
            applyStimulus(r, ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                          2'($urandom_range(0, 3)), $urandom_range(0, 1), jr);
        end

        @(negedge clk);
        #1;
        compareEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mc_ifu.md
MC_IFU -- requirements
Module: mc_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter IM_WORDS, default 1024, meaning instruction-memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pc_wr  input  1  PC update enable from the controller.
REQ-006 SHALL have port ir_wr  input  1  instruction-register load enable; asserted in fetch state S1.
REQ-007 SHALL have port npc_sel  input  2  next-PC source: 00 seq, 01 branch, 10 jump, 11 register.
REQ-008 SHALL have port br_cond  input  1  resolved branch condition, valid when npc_sel=01.
REQ-009 SHALL have port jr_addr  input  32  register target used for jr/jalr.
REQ-010 SHALL have port pc  output  32  current PC register.
REQ-011 SHALL have port instr  output  32  instruction register (stored instruction).
REQ-012 SHALL have port instr_valid  output  1  high once IR has loaded at least once since reset.
REQ-013 SHALL have port fetch_err  output  1  sticky fetch-fault flag (see Configuration).
REQ-014 SHALL hold instruction memory as an internal IM_WORDS x 32 array named im, loadable by $readmemh from a bench, read-only to the design.

Function
REQ-015 SHALL read memory asynchronously at word index pc[11:2]; with the default depth, pc bits above 11 are ignored.
REQ-016 SHALL, on a clk edge with ir_wr=1, load instr <= im[pc[11:2]] using the pre-edge pc.
REQ-017 SHALL, on a clk edge with pc_wr=1, load pc <= npc; when pc_wr=0, pc holds.
REQ-018 SHALL compute npc for 00 as pc+4.
REQ-019 SHALL compute npc for 01 as pc + sign_extend(instr[15:0])<<2 when br_cond=1; with br_cond=0, npc=pc (pc already advanced in S1).
REQ-020 SHALL compute npc for 10 as {pc[31:28], instr[25:0], 2'b00}.
REQ-021 SHALL compute npc for 11 as jr_addr.
REQ-022 SHALL, with pc_wr=1 and ir_wr=1 on the same edge, load instr from the old pc and pc from npc, so a fetch fetches and increments in one cycle.
REQ-023 SHALL perform all additions modulo 2^32; wrap-around is silent.
REQ-024 SHALL raise instr_valid on the first ir_wr edge after reset and hold it until reset.
REQ-025 SHALL have zero-cycle output latency: pc and instr are register outputs, visible immediately after the capturing edge.

Reset
REQ-026 SHALL, on an edge with rst=1, set pc=RESET_PC, instr=0, instr_valid=0, and fetch_err=0, with rst overriding pc_wr and ir_wr on that edge.
REQ-027 SHALL leave im contents unchanged by reset, including a reset asserted mid-program.

Configuration
REQ-028 SHALL, with macro IFU_ADDR_CHECK_EN defined, check the address on each ir_wr edge. If pc[1:0]!=0 or pc lies outside [RESET_PC, RESET_PC+4*IM_WORDS-4], instr loads 32'h0000_0000 (nop) and fetch_err sets and stays set until reset.
REQ-029 SHALL, without IFU_ADDR_CHECK_EN, keep fetch_err constant 0, perform no address check, and let the index wrap via pc[11:2].

Verification
REQ-030 SHALL cover reset: rst=1 for 2 edges, then 0 -> pc=32'h0000_3000, instr=0, instr_valid=0.
REQ-031 SHALL cover fetch: im[0]=32'h2008_0005, then pc_wr=1, ir_wr=1, npc_sel=00 for one edge -> instr=32'h2008_0005, pc=32'h0000_3004, instr_valid=1.
REQ-032 SHALL cover branch taken: pc=32'h0000_3004, instr=32'h0411_FFFE (bltzal, imm=-2), npc_sel=01, br_cond=1, pc_wr=1 -> pc=32'h0000_2FFC.
REQ-033 SHALL cover branch not taken and jump. With the branch case above but br_cond=0 -> pc stays 32'h0000_3004. With instr=32'h0C00_0C10, npc_sel=10 -> pc=32'h0000_3040.
REQ-034 SHALL cover jr and hold: jr_addr=32'h0000_3010, npc_sel=11, pc_wr=1 -> pc=32'h0000_3010. The next edge with pc_wr=0, ir_wr=0 -> pc and instr unchanged.
REQ-035 SHALL cover the IFU_ADDR_CHECK_EN case: jr_addr=32'h0000_3002 loaded, then ir_wr=1 -> instr=0, fetch_err=1, staying 1 after further valid fetches until rst.
